// File: rtl/mips_cpu_lsu.sv
// MIPS load/store unit: one request per transaction, drives a byte-enabled
// word-aligned memory bus and returns extended/merged load data.
module mips_cpu_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rt_q;
  logic [31:0] wait_cnt;

  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic        is_store;
  logic        req_ok;

  assign off_in = req_addr[1:0];

  // Request decode: lanes, store data and legality from the incoming request.
  always_comb begin
    be_in    = '0;
    wd_in    = '0;
    is_store = 1'b0;
    req_ok   = 1'b0;
    case (req_opcode)
      OP_LB, OP_LBU: begin
        be_in  = 4'b0001 << off_in;
        req_ok = 1'b1;
      end
      OP_LH, OP_LHU: begin
        be_in  = off_in[1] ? 4'b1100 : 4'b0011;
        req_ok = ~off_in[0];
      end
      OP_LW: begin
        be_in  = 4'b1111;
        req_ok = (off_in == 2'b00);
      end
      OP_LWL: begin
        case (off_in)
          2'd0:    be_in = 4'b0001;
          2'd1:    be_in = 4'b0011;
          2'd2:    be_in = 4'b0111;
          default: be_in = 4'b1111;
        endcase
        req_ok = 1'b1;
      end
      OP_LWR: begin
        be_in  = 4'b1111 << off_in;
        req_ok = 1'b1;
      end
      OP_SB: begin
        be_in    = 4'b0001 << off_in;
        wd_in    = {4{req_wdata[7:0]}};
        is_store = 1'b1;
        req_ok   = 1'b1;
      end
      OP_SH: begin
        be_in    = off_in[1] ? 4'b1100 : 4'b0011;
        wd_in    = {2{req_wdata[15:0]}};
        is_store = 1'b1;
        req_ok   = ~off_in[0];
      end
      OP_SW: begin
        be_in    = 4'b1111;
        wd_in    = req_wdata;
        is_store = 1'b1;
        req_ok   = (off_in == 2'b00);
      end
      default: ;
    endcase
  end

  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [4:0]  sh_lwl;
  logic [4:0]  sh_lwr;
  logic [31:0] load_data;

  assign rd_shift = mem_readdata >> {off_q, 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = off_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
  assign sh_lwl   = {~off_q, 3'b000};
  assign sh_lwr   = {off_q, 3'b000};

  always_comb begin
    load_data = '0;
    case (op_q)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'h0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'h0, rd_half};
      OP_LW:   load_data = mem_readdata;
      OP_LWL:  load_data = (mem_readdata << sh_lwl) | (rt_q & ~(32'hFFFF_FFFF << sh_lwl));
      OP_LWR:  load_data = (mem_readdata >> sh_lwr) | (rt_q & ~(32'hFFFF_FFFF >> sh_lwr));
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= '0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      op_q           <= '0;
      off_q          <= '0;
      rt_q           <= '0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_opcode;
            off_q     <= off_in;
            rt_q      <= req_rt_old;
            req_ready <= 1'b0;
            if (req_ok) begin
              state          <= ACCESS;
              mem_address    <= {req_addr[31:2], 2'b00};
              mem_byteenable <= be_in;
              mem_writedata  <= wd_in;
              mem_read       <= ~is_store;
              mem_write      <= is_store;
              wait_cnt       <= '0;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (!mem_waitrequest) begin
            state      <= RESP;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= mem_read ? load_data : '0;
          end else if (TIMEOUT != 0 && wait_cnt == TIMEOUT - 1) begin
            state      <= RESP;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Directed testbench for mips_cpu_lsu with hand-computed expected values.
module tb_mips_cpu_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  int unsigned vectors;
  int unsigned errors;

  mips_cpu_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rt);
    chk1("ready_before_accept", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = a;
    req_wdata  = wd;
    req_rt_old = rt;
    tick();
    req_valid  = 1'b0;
    req_opcode = 6'h3F;
    req_wdata  = 32'h0;
  endtask

  // Zero-wait transaction: checks the ACCESS cycle then the RESP cycle.
  task automatic run_zero(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] rd,
                          input logic [3:0] exp_be, input logic exp_wr,
                          input logic [31:0] exp_wd, input logic [31:0] exp_resp);
    mem_waitrequest = 1'b0;
    mem_readdata    = rd;
    send(op, a, wd, rt);
    chk({tag, "_addr"}, mem_address, {a[31:2], 2'b00});
    chk({tag, "_be"}, {28'h0, mem_byteenable}, {28'h0, exp_be});
    chk1({tag, "_read"}, mem_read, ~exp_wr);
    chk1({tag, "_write"}, mem_write, exp_wr);
    if (exp_wr) chk({tag, "_wdata"}, mem_writedata, exp_wd);
    chk1({tag, "_novalid"}, resp_valid, 1'b0);
    tick();
    chk1({tag, "_valid"}, resp_valid, 1'b1);
    chk1({tag, "_err"}, resp_err, 1'b0);
    chk({tag, "_rdata"}, resp_rdata, exp_resp);
    chk1({tag, "_strobe_drop"}, mem_read | mem_write, 1'b0);
    tick();
    chk1({tag, "_pulse_end"}, resp_valid, 1'b0);
  endtask

  task automatic run_bad(input string tag, input logic [5:0] op, input logic [31:0] a);
    send(op, a, 32'h0, 32'h0);
    chk1({tag, "_valid"}, resp_valid, 1'b1);
    chk1({tag, "_err"}, resp_err, 1'b1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk1({tag, "_nostrobe"}, mem_read | mem_write, 1'b0);
    tick();
    chk1({tag, "_pulse_end"}, resp_valid, 1'b0);
  endtask

  initial begin
    vectors         = 0;
    errors          = 0;
    rst             = 1'b1;
    req_valid       = 1'b0;
    req_opcode      = 6'h0;
    req_addr        = 32'h0;
    req_wdata       = 32'h0;
    req_rt_old      = 32'h0;
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'h0;
    tick();
    tick();
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_valid", resp_valid, 1'b0);
    chk1("rst_err", resp_err, 1'b0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk1("rst_read", mem_read, 1'b0);
    chk1("rst_write", mem_write, 1'b0);
    chk("rst_be", {28'h0, mem_byteenable}, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_writedata, 32'h0);
    rst = 1'b0;
    tick();

    run_zero("lw",  6'h23, 32'h10, 32'h0, 32'h0, 32'h8899AABB, 4'b1111, 1'b0, 32'h0, 32'h8899AABB);
    run_zero("lb",  6'h20, 32'h13, 32'h0, 32'h0, 32'h80FF0000, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80);
    run_zero("lbu", 6'h24, 32'h13, 32'h0, 32'h0, 32'h80FF0000, 4'b1000, 1'b0, 32'h0, 32'h00000080);
    run_zero("lh",  6'h21, 32'h42, 32'h0, 32'h0, 32'h80FF1234, 4'b1100, 1'b0, 32'h0, 32'hFFFF80FF);
    run_zero("lhu", 6'h25, 32'h40, 32'h0, 32'h0, 32'h12348001, 4'b0011, 1'b0, 32'h0, 32'h00008001);
    run_zero("lwl", 6'h22, 32'h01, 32'h0, 32'h11223344, 32'hAABBCCDD, 4'b0011, 1'b0, 32'h0, 32'hCCDD3344);
    run_zero("lwr", 6'h26, 32'h01, 32'h0, 32'h11223344, 32'hAABBCCDD, 4'b1110, 1'b0, 32'h0, 32'h11AABBCC);
    run_zero("lwl3", 6'h22, 32'h03, 32'h0, 32'h11223344, 32'hAABBCCDD, 4'b1111, 1'b0, 32'h0, 32'hAABBCCDD);
    run_zero("lwr0", 6'h26, 32'h00, 32'h0, 32'h11223344, 32'hAABBCCDD, 4'b1111, 1'b0, 32'h0, 32'hAABBCCDD);
    run_zero("sb",  6'h28, 32'h51, 32'h000000A5, 32'h0, 32'h0, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h0);
    run_zero("sw",  6'h2B, 32'h60, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0);

    // SH with three stall cycles: bus outputs must hold for four cycles.
    mem_waitrequest = 1'b1;
    send(6'h29, 32'h22, 32'h1234BEEF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk1("sh_write_held", mem_write, 1'b1);
      chk("sh_addr_held", mem_address, 32'h20);
      chk("sh_be_held", {28'h0, mem_byteenable}, 32'hC);
      chk("sh_wdata_held", mem_writedata, 32'hBEEFBEEF);
      chk1("sh_no_resp_yet", resp_valid, 1'b0);
      if (i == 3) mem_waitrequest = 1'b0;
      tick();
    end
    chk1("sh_valid", resp_valid, 1'b1);
    chk1("sh_err", resp_err, 1'b0);
    chk("sh_rdata", resp_rdata, 32'h0);
    chk1("sh_write_drop", mem_write, 1'b0);
    tick();

    run_bad("lw_misaligned", 6'h23, 32'h06);
    run_bad("addiu", 6'h09, 32'h00);
    run_bad("sh_misaligned", 6'h29, 32'h21);
    run_bad("lhu_misaligned", 6'h25, 32'h03);

    // Stuck waitrequest with TIMEOUT=4: four strobe cycles, then error response.
    mem_waitrequest = 1'b1;
    send(6'h23, 32'h30, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk1("to_read_held", mem_read, 1'b1);
      chk1("to_no_resp_yet", resp_valid, 1'b0);
      tick();
    end
    chk1("to_valid", resp_valid, 1'b1);
    chk1("to_err", resp_err, 1'b1);
    chk1("to_read_drop", mem_read, 1'b0);
    tick();
    chk1("to_pulse_end", resp_valid, 1'b0);
    chk1("to_ready", req_ready, 1'b1);

    // Reset in the middle of ACCESS.
    send(6'h20, 32'h00, 32'h0, 32'h0);
    chk1("rstmid_read", mem_read, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("rstmid_read_drop", mem_read, 1'b0);
    chk1("rstmid_no_resp", resp_valid, 1'b0);
    chk1("rstmid_ready", req_ready, 1'b1);
    tick();
    chk1("rstmid_no_resp2", resp_valid, 1'b0);
    chk1("rstmid_ready2", req_ready, 1'b1);

    // Unit still usable after the abort.
    mem_waitrequest = 1'b0;
    run_zero("post_lw", 6'h23, 32'h7C, 32'h0, 32'h0, 32'h01020304, 4'b1111, 1'b0, 32'h0, 32'h01020304);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
